binary_ripple_counter_8: RTL and testbench
==========================================

Name: binary_ripple_counter_8

Overview:
- 8-bit asynchronous (ripple) binary up-counter built from a chain of negative-edge T flip-flops.
- Stage 0 is clocked by the system clock and enabled by toggle.
- Each higher stage is clocked by the falling edge of the previous stage's output.
- Used as a simple event/cycle counter in the logic-design exercise set; output A is the count value.

Parameters:
- WIDTH, 8, number of counter stages / output width. The bench uses 8; other values must also elaborate.

Ports:
- clock  input  1  system clock; stage 0 samples on the falling edge.
- reset  input  1  asynchronous, active-low reset; clears all stages.
- A  output  WIDTH (8)  counter value; A[0] is the LSB.
- toggle  input  1  count enable (T input of stage 0).
- Port declaration order: A, toggle, reset, clock, because the module is instantiated positionally in that order.

Behaviour:
- Structure: WIDTH instances of a T flip-flop submodule (ports Q, T, clk, rst_n), each with a registered Q.
- Stage 0: T = toggle, clk = clock.
- Stage i (i ≥ 1): T = 1'b1, clk = A[i-1].
- Each stage toggles Q on the falling edge of its clk when T = 1, and holds when T = 0.
- Result: A increments by 1 on each falling edge of clock while toggle = 1. A holds while toggle = 0.
- Reset:
  - reset = 0 forces A = 0 immediately, with no clock required (asynchronous).
  - Reset applies to every stage and overrides all clock edges.
  - While reset = 0, A stays 0 regardless of clock or toggle.
- Reset release: counting resumes on the first falling clock edge after reset returns to 1 with toggle = 1. No minimum recovery time is modelled in RTL.
- Reset mid-count: A clears at once; the count restarts from 0.
- Wrap-around: 255 + 1 → 0. Every stage falls in a single ripple; no carry-out or overflow flag.
- Toggle timing:
  - toggle is sampled only by stage 0 at the falling clock edge.
  - toggle changes between edges affect the next edge only.
  - Deasserting toggle never interrupts a ripple already in progress.
- Ripple settling:
  - Intermediate values may appear briefly during a ripple, e.g. 0x7F → 0x7E → 0x7C … → 0x80.
  - Zero-delay RTL; the final value must be stable before the next falling clock edge.
  - Consumers must sample A only after the falling edge has settled (e.g. on the rising edge).
- Power-up: undefined until the first reset; reset is required before use.
- Rising edges of clock have no effect.

Test Plan:
- Reset assert: reset = 0 for 1 time unit with clock idle → A = 0x00 immediately. Stays 0x00 while held low, despite clock edges and toggle = 1.
- Hold: reset = 1, toggle = 0, clock period 10 (falling edges at 10, 20, …) for 160 units → A remains 0x00.
- Count: toggle = 1 for 16 falling edges → A = 0x01 after the first edge, 0x10 after the 16th. Each sample is taken at the rising edge before the next fall.
- Freeze: toggle returns to 0 after 16 counts, run 160 more units → A holds 0x10.
- Wrap: with toggle = 1, run 255 edges from 0 → A = 0xFF. The next edge → A = 0x00, with all bits settled before the next rising edge.
- Async reset mid-count: at A = 0x37 pull reset low between clock edges → A = 0x00 without a clock edge. Release and count 3 edges → A = 0x03.

Source files
------------

// File: rtl/binary_ripple_counter_8.sv
// binary_ripple_counter_8: ripple up-counter built from a chain of falling-edge T flip-flops
module binary_ripple_counter_8 #(
   parameter int WIDTH = 8
) (
   output logic [WIDTH-1:0] A,
   input  logic             toggle,
   input  logic             reset,
   input  logic             clock
);
   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_stage
         if (i == 0) begin : g_first
            binary_ripple_counter_8_tff u_tff (
               .Q    (A[0]),
               .T    (toggle),
               .clk  (clock),
               .rst_n(reset)
            );
         end else begin : g_next
            binary_ripple_counter_8_tff u_tff (
               .Q    (A[i]),
               .T    (1'b1),
               .clk  (A[i-1]),
               .rst_n(reset)
            );
         end
      end
   endgenerate
endmodule

// binary_ripple_counter_8_tff: falling-edge T flip-flop with asynchronous active-low clear
module binary_ripple_counter_8_tff (
   output logic Q,
   input  logic T,
   input  logic clk,
   input  logic rst_n
);
   logic q_d;
   logic q_q;
   // next state: invert when T is set, otherwise hold
   always_comb begin
      q_d = T ? ~q_q : q_q;
   end
   // state register: clears at once on reset, updates on the falling clock edge
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) q_q <= 1'b0;
      else        q_q <= q_d;
   end
   assign Q = q_q;
endmodule

// File: tb/tb_binary_ripple_counter_8.sv
// tb_binary_ripple_counter_8: scoreboard bench for the ripple counter against a modulo-256 count model
module tb_binary_ripple_counter_8;
   logic [7:0] A;
   logic       toggle;
   logic       reset;
   logic       clock;
   logic       clk_run;
   int         checks;
   int         errors;
   int         cnt;
   logic [7:0] exp_q[$];

   binary_ripple_counter_8 #(.WIDTH(8)) dut (
      .A     (A),
      .toggle(toggle),
      .reset (reset),
      .clock (clock)
   );

   // clock stays idle until the bench starts it; falling edges every 10 units afterwards
   initial begin
      clock = 1'b0;
      wait (clk_run);
      forever begin
         #5 clock = 1'b1;
         #5 clock = 1'b0;
      end
   end

   // reference model: reset clears the count immediately
   always @(negedge reset) cnt = 0;

   // reference model: each falling clock edge adds one (mod 256) when enabled and out of reset
   always @(negedge clock) begin
      if (reset && toggle) cnt = (cnt + 1) % 256;
      exp_q.push_back(8'(cnt));
   end

   // monitor: after each rising edge the settled count is compared with the oldest expectation
   always @(posedge clock) begin
      #1;
      if (exp_q.size() > 0) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         checks++;
         if (A !== e) begin
            errors++;
            $display("FAIL count t=%0t got %02h expected %02h", $time, A, e);
         end
      end
   end

   task automatic check(input string name, input logic [7:0] e);
      checks++;
      if (A !== e) begin
         errors++;
         $display("FAIL %s got %02h expected %02h", name, A, e);
      end
   endtask

   // called at a rising edge + 3; leaves the bench at the same phase after n falling edges
   task automatic run(input int n, input logic t);
      toggle = t;
      repeat (n) begin
         @(posedge clock);
         #3;
      end
   endtask

   // asynchronous reset between edges; A must clear with no clock edge
   task automatic reset_pulse();
      reset = 1'b0;
      #1;
      check("async_reset", 8'h00);
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      checks  = 0;
      errors  = 0;
      cnt     = 0;
      clk_run = 1'b0;
      toggle  = 1'b1;
      reset   = 1'b1;
      #1 reset = 1'b0;
      #1 check("reset_idle", 8'h00);
      clk_run = 1'b1;
      @(posedge clock);
      #3;
      run(4, 1'b1);
      check("reset_held", 8'h00);
      reset = 1'b1;
      run(16, 1'b0);
      check("hold", 8'h00);
      run(1, 1'b1);
      check("first_count", 8'h01);
      run(15, 1'b1);
      check("count16", 8'h10);
      run(16, 1'b0);
      check("freeze", 8'h10);
      reset_pulse();
      run(255, 1'b1);
      check("full", 8'hFF);
      run(1, 1'b1);
      check("wrap", 8'h00);
      run(55, 1'b1);
      check("mid_count", 8'h37);
      reset_pulse();
      run(3, 1'b1);
      check("restart", 8'h03);
      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(0, 3) == 0) reset_pulse();
         run($urandom_range(1, 40), 1'($urandom_range(0, 1)));
         check("random", 8'(cnt));
      end
      run(2, 1'b0);
      checks++;
      if (exp_q.size() > 1) begin
         errors++;
         $display("FAIL drain got %0d expected at most 1", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
